pwm_config_scheduler: RTL and testbench

PWM_CONFIG_SCHEDULER -- requirements
Module: pwm_config_scheduler

---
 rtl/PKG_pwm.sv | 21 ++
 rtl/pwm_cfg_timeout_cnt.sv | 28 ++
 rtl/pwm_config_scheduler.sv | 129 ++++++++++++
 tb/tb_pwm_config_scheduler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/PKG_pwm.sv
// Shared PWM types and the configuration scheduler FSM encoding.
//   _pwm_onoff      : PWM enable bit
//   _mask_mode      : output mask mode bit
//   _count_mode     : counter mode field (PWMCOUNT_WIDTH-1 bits)
//   _cfgsched_state : scheduler FSM states
package PKG_pwm;

    // act_word is PWMCOUNT_WIDTH+1 bits = {onoff, mask, count}
    localparam int PWMCOUNT_WIDTH = 3;

    typedef logic                      _pwm_onoff;
    typedef logic                      _mask_mode;
    typedef logic [PWMCOUNT_WIDTH-2:0] _count_mode;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } _cfgsched_state;

endpackage

// File: rtl/pwm_cfg_timeout_cnt.sv
// Saturating wait counter for a pending configuration.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : restart at zero (wins over enable)
//   enable    : count one cycle
//   terminal  : count has reached TERMINAL; counter holds there
module pwm_cfg_timeout_cnt #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [WIDTH-1:0] count;

    assign terminal = (count == TERMINAL);

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (enable && !terminal)
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/pwm_config_scheduler.sv
// Schedules PWM configuration updates onto period boundaries.
// A configuration accepted via cfg_valid/cfg_ready is held in a shadow
// register and copied to the active outputs either immediately, at the
// next period_end, or after TIMEOUT_CYCLES cycles of waiting.
//   cfg_*          : offered configuration and handshake
//   period_end     : period wrap pulse from the PWM counter
//   act_*/act_word : active configuration
//   counter_clear  : restart PWM counter with the new configuration
//   update_done    : pulse, new configuration in effect
//   timeout_flag   : sticky, last apply was forced by timeout
//   busy           : configuration pending or being applied
module pwm_config_scheduler
    import PKG_pwm::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  _pwm_onoff               cfg_onoff,
    input  _mask_mode               cfg_mask,
    input  _count_mode              cfg_count,
    input  logic                    cfg_immediate,
    input  logic                    period_end,
    output _pwm_onoff               act_onoff,
    output _mask_mode               act_mask,
    output _count_mode              act_count,
    output logic [PWMCOUNT_WIDTH:0] act_word,
    output logic                    counter_clear,
    output logic                    update_done,
    output logic                    timeout_flag,
    output logic                    busy
);

    localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    _cfgsched_state state, next_state;
    _pwm_onoff      sh_onoff;
    _mask_mode      sh_mask;
    _count_mode     sh_count;
    logic           forced;
    logic           forced_next;
    logic           transfer;
    logic           tmo_term;

    assign transfer = cfg_valid & cfg_ready;
    assign act_word = {act_onoff, act_mask, act_count};

    // Counter only runs while waiting; any new transfer restarts the wait.
    pwm_cfg_timeout_cnt #(
        .WIDTH    (TW),
        .TERMINAL (TMO_LAST)
    ) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .clear    (transfer || (state != PENDING)),
        .enable   (state == PENDING),
        .terminal (tmo_term)
    );

    always_comb begin
        next_state  = state;
        forced_next = 1'b0;
        case (state)
            IDLE: begin
                // Nothing is running, so there is no boundary to wait for.
                if (transfer)
                    next_state = (cfg_immediate || !act_onoff) ? APPLY : PENDING;
            end
            PENDING: begin
                if ((transfer && cfg_immediate) || period_end) begin
                    next_state = APPLY;
                end else if (!transfer && tmo_term) begin
                    // A transfer in the same cycle restarts the wait instead.
                    next_state  = APPLY;
                    forced_next = 1'b1;
                end
            end
            APPLY:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cfg_ready     <= 1'b0;
            busy          <= 1'b0;
            sh_onoff      <= '0;
            sh_mask       <= '0;
            sh_count      <= '0;
            act_onoff     <= '0;
            act_mask      <= '0;
            act_count     <= '0;
            forced        <= 1'b0;
            counter_clear <= 1'b0;
            update_done   <= 1'b0;
            timeout_flag  <= 1'b0;
        end else begin
            state         <= next_state;
            cfg_ready     <= (next_state != APPLY);
            busy          <= (next_state != IDLE);
            forced        <= forced_next;
            counter_clear <= 1'b0;
            update_done   <= 1'b0;

            if (transfer) begin
                sh_onoff     <= cfg_onoff;
                sh_mask      <= cfg_mask;
                sh_count     <= cfg_count;
                timeout_flag <= 1'b0;
            end

            if (state == APPLY) begin
                act_onoff     <= sh_onoff;
                act_mask      <= sh_mask;
                act_count     <= sh_count;
                update_done   <= 1'b1;
                // Restart the counter on power-up or when its mode changes.
                counter_clear <= (!act_onoff && sh_onoff) || (act_count != sh_count);
                if (forced)
                    timeout_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_config_scheduler.sv
module tb_pwm_config_scheduler;
    import PKG_pwm::*;

    localparam int T = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    cfg_valid = 1'b0;
    logic                    cfg_ready;
    _pwm_onoff               cfg_onoff = '0;
    _mask_mode               cfg_mask = '0;
    _count_mode              cfg_count = '0;
    logic                    cfg_immediate = 1'b0;
    logic                    period_end = 1'b0;
    _pwm_onoff               act_onoff;
    _mask_mode               act_mask;
    _count_mode              act_count;
    logic [PWMCOUNT_WIDTH:0] act_word;
    logic                    counter_clear;
    logic                    update_done;
    logic                    timeout_flag;
    logic                    busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_config_scheduler #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_onoff(cfg_onoff), .cfg_mask(cfg_mask), .cfg_count(cfg_count),
        .cfg_immediate(cfg_immediate), .period_end(period_end),
        .act_onoff(act_onoff), .act_mask(act_mask), .act_count(act_count),
        .act_word(act_word), .counter_clear(counter_clear),
        .update_done(update_done), .timeout_flag(timeout_flag), .busy(busy)
    );

    // Behavioural model: a config is either waiting for a boundary (m_wait_on),
    // or due to land on the next edge (m_due), or absent.
    logic [PWMCOUNT_WIDTH:0] m_act, m_cfg;
    logic m_ready, m_due, m_wait_on, m_forced, m_done, m_clr, m_tflag;
    int   m_age;

    task automatic model_step();
        logic xfer;
        if (rst) begin
            m_act = '0; m_cfg = '0; m_ready = 0; m_due = 0; m_wait_on = 0;
            m_forced = 0; m_done = 0; m_clr = 0; m_tflag = 0; m_age = 0;
        end else begin
            xfer   = cfg_valid && m_ready;
            m_done = 0;
            m_clr  = 0;
            if (m_due) begin
                m_clr  = (!m_act[PWMCOUNT_WIDTH] && m_cfg[PWMCOUNT_WIDTH]) ||
                         (m_act[PWMCOUNT_WIDTH-2:0] != m_cfg[PWMCOUNT_WIDTH-2:0]);
                m_act  = m_cfg;
                m_done = 1;
                if (m_forced) m_tflag = 1;
                m_due = 0; m_forced = 0;
            end else if (xfer) begin
                m_cfg   = {cfg_onoff, cfg_mask, cfg_count};
                m_tflag = 0;
                m_age   = 0;
                if (cfg_immediate || !m_act[PWMCOUNT_WIDTH] || (m_wait_on && period_end)) begin
                    m_due = 1; m_wait_on = 0;
                end else begin
                    m_wait_on = 1;
                end
            end else if (m_wait_on) begin
                if (period_end) begin
                    m_due = 1; m_wait_on = 0;
                end else if (m_age == T - 1) begin
                    m_due = 1; m_wait_on = 0; m_forced = 1;
                end else begin
                    m_age++;
                end
            end
            m_ready = !m_due;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge,
    // then compare every output just after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("cfg_ready",     32'(cfg_ready),     32'(m_ready));
        chk("act_word",      32'(act_word),      32'(m_act));
        chk("update_done",   32'(update_done),   32'(m_done));
        chk("counter_clear", 32'(counter_clear), 32'(m_clr));
        chk("timeout_flag",  32'(timeout_flag),  32'(m_tflag));
        chk("busy",          32'(busy),          32'(m_due || m_wait_on));
    endtask

    task automatic offer(input logic on, input logic mk, input logic [1:0] cnt,
                         input logic imm, input logic pe);
        cfg_valid = 1'b1; cfg_onoff = on; cfg_mask = mk; cfg_count = cnt;
        cfg_immediate = imm; period_end = pe;
    endtask

    task automatic quiet(input logic pe);
        cfg_valid = 1'b0; cfg_immediate = 1'b0; period_end = pe;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick(); tick();
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_word",  32'(act_word),  32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(cfg_ready), 32'd1);

        // period_end while idle does nothing
        quiet(1'b1); tick(); quiet(1'b0); tick();
        chk("idle_pe_busy", 32'(busy), 32'd0);

        // PWM off: non-immediate config goes straight through
        offer(1, 0, 2'd1, 0, 0); tick();
        quiet(0); tick();
        chk("pwrup_word", 32'(act_word),      32'b1001);
        chk("pwrup_done", 32'(update_done),   32'd1);
        chk("pwrup_clr",  32'(counter_clear), 32'd1);
        tick();

        // Running: wait for boundary (6 idle cycles, inside the T=8 window)
        offer(1, 1, 2'd1, 0, 0); tick();
        quiet(0);
        for (int i = 0; i < 6; i++) tick();
        quiet(1); tick();
        quiet(0);
        chk("bnd_one_edge", 32'(act_mask), 32'd0);
        tick();
        chk("bnd_mask", 32'(act_mask),      32'd1);
        chk("bnd_clr",  32'(counter_clear), 32'd0);
        tick();

        // Running: no boundary -> forced apply
        offer(1, 0, 2'd1, 0, 0); tick();
        quiet(0);
        for (int i = 0; i < T + 2; i++) tick();
        chk("tmo_flag", 32'(timeout_flag), 32'd1);
        offer(1, 0, 2'd1, 1, 0); tick();
        quiet(0);
        chk("tmo_flag_clr", 32'(timeout_flag), 32'd0);
        tick(); tick();

        // Second transfer coincides with period_end
        offer(1, 1, 2'd1, 0, 0); tick();
        quiet(0); tick(); tick();
        offer(1, 0, 2'd3, 0, 1); tick();
        quiet(0);
        chk("ovr_no_done", 32'(update_done), 32'd0);
        tick();
        chk("ovr_word", 32'(act_word),    32'b1011);
        chk("ovr_done", 32'(update_done), 32'd1);
        tick();
        chk("ovr_single", 32'(update_done), 32'd0);

        // period_end on the timeout cycle wins
        offer(1, 1, 2'd2, 0, 0); tick();
        quiet(0);
        for (int i = 0; i < T - 1; i++) tick();
        quiet(1); tick();
        quiet(0); tick();
        chk("race_word", 32'(act_word),     32'b1110);
        chk("race_done", 32'(update_done),  32'd1);
        chk("race_flag", 32'(timeout_flag), 32'd0);
        tick();

        // Reset while pending discards the config
        offer(1, 0, 2'd2, 0, 0); tick();
        quiet(0); tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("rstp_word",  32'(act_word),  32'd0);
        chk("rstp_busy",  32'(busy),      32'd0);
        chk("rstp_ready", 32'(cfg_ready), 32'd0);
        tick();
        chk("rstp_ready1", 32'(cfg_ready),   32'd1);
        chk("rstp_nodone", 32'(update_done), 32'd0);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
